// File: rtl/load_store_unit_pkg.sv
// Shared types and func3 encodings for the memory-stage load/store unit.
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RD,
        DONE
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/load_format.sv
// Selects the addressed byte/half lane of a read word and sign- or zero-extends it.
module load_format
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(rdata >> {lane, 3'b000});
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
        case (func3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'h0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'h0, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage access unit: turns func3 loads/stores into byte-enabled word bus
// transactions over a req/gnt/rvalid handshake and stalls the pipeline until done.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DM_ADDRESS = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [2:0]            func3,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  stall,
    output logic                  access_err,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [DM_ADDRESS-3:0] bus_addr,
    output logic [3:0]            bus_be,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_gnt,
    input  logic                  bus_rvalid,
    input  logic [DATA_W-1:0]     bus_rdata
);

    lsu_state_e            state_q, state_d;
    logic [DM_ADDRESS-3:0] bus_addr_q;
    logic                  bus_we_q;
    logic [3:0]            bus_be_q;
    logic [DATA_W-1:0]     bus_wdata_q;
    logic [DATA_W-1:0]     rd_data_q;
    logic [2:0]            func3_q;
    logic [1:0]            lane_q;

    logic              op_valid, is_write, illegal, misaligned, op_start;
    logic [3:0]        be_next;
    logic [DATA_W-1:0] wdata_next;
    logic [DATA_W-1:0] load_word;

    assign op_valid = mem_read | mem_write;
    assign is_write = mem_write & ~mem_read;

    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        unique case (func3)
            F3_B, F3_H, F3_W: illegal = 1'b0;
            F3_BU, F3_HU:     illegal = is_write;
            default:          illegal = 1'b1;
        endcase
        if ((func3 == F3_H || func3 == F3_HU) && addr[0]) misaligned = 1'b1;
        if (func3 == F3_W && addr[1:0] != 2'b00) misaligned = 1'b1;
    end

    assign access_err = (state_q == IDLE) & op_valid & (illegal | misaligned);
    assign op_start   = (state_q == IDLE) & op_valid & ~illegal & ~misaligned;

    // Size is func3[1:0] for every legal code, so loads share the store lane rule.
    always_comb begin
        case (func3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << addr[1:0];
                wdata_next = {4{wr_data[7:0]}};
            end
            2'b01: begin
                be_next    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{wr_data[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = wr_data;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        bus_req = 1'b0;
        case (state_q)
            IDLE: begin
                if (op_start) begin
                    state_d = REQ;
                    stall   = 1'b1;
                end
            end
            REQ: begin
                bus_req = 1'b1;
                stall   = 1'b1;
                if (bus_gnt) state_d = bus_we_q ? DONE : WAIT_RD;
            end
            WAIT_RD: begin
                stall = 1'b1;
                if (bus_rvalid) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    load_format u_load_format (
        .func3 (func3_q),
        .lane  (lane_q),
        .rdata (bus_rdata),
        .data  (load_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bus_addr_q  <= '0;
            bus_we_q    <= 1'b0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= '0;
            rd_data_q   <= '0;
            func3_q     <= 3'b000;
            lane_q      <= 2'b00;
        end else begin
            state_q <= state_d;
            if (op_start) begin
                bus_addr_q  <= addr[DM_ADDRESS-1:2];
                bus_we_q    <= is_write;
                bus_be_q    <= be_next;
                bus_wdata_q <= wdata_next;
                func3_q     <= func3;
                lane_q      <= addr[1:0];
            end else if (state_q == DONE) begin
                bus_addr_q  <= '0;
                bus_we_q    <= 1'b0;
                bus_be_q    <= 4'b0000;
                bus_wdata_q <= '0;
            end
            if (state_q == WAIT_RD && bus_rvalid) rd_data_q <= load_word;
        end
    end

    assign bus_addr  = bus_addr_q;
    assign bus_we    = bus_we_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word-memory bus responder.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [8:0]  addr;
    logic [31:0] wr_data;
    logic [2:0]  func3;
    logic [31:0] rd_data;
    logic        stall, access_err;
    logic        bus_req, bus_we;
    logic [6:0]  bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    logic [31:0] mem [0:127];
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_W(32), .DM_ADDRESS(9)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .wr_data    (wr_data),
        .func3      (func3),
        .rd_data    (rd_data),
        .stall      (stall),
        .access_err (access_err),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Entered and left at posedge+1 in IDLE; drives one op until DONE, then drops inputs.
    task automatic do_op(input string tag, input logic rd, input logic wr, input logic [8:0] a,
                         input logic [31:0] wd, input logic [2:0] f3, input int gdly,
                         input int rdly, output int stall_cyc, output logic [3:0] be_o,
                         output logic [31:0] wdata_o, output logic [6:0] baddr_o,
                         output logic we_o, output int grants);
        int  req_n = 0;
        int  wait_n = 0;
        bit  done = 0;
        stall_cyc = 0;
        grants = 0;
        be_o = '0;
        wdata_o = '0;
        baddr_o = '0;
        we_o = 1'b0;
        mem_read = rd;
        mem_write = wr;
        addr = a;
        wr_data = wd;
        func3 = f3;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            bus_gnt = 1'b0;
            bus_rvalid = 1'b0;
            #1;
            if (!stall && cyc > 0) begin
                done = 1;
                check({tag, " req@done"}, 32'(bus_req), 32'd0);
            end else begin
                if (stall) stall_cyc++;
                if (bus_req) begin
                    be_o = bus_be;
                    wdata_o = bus_wdata;
                    baddr_o = bus_addr;
                    we_o = bus_we;
                    if (req_n == gdly) begin
                        bus_gnt = 1'b1;
                        grants++;
                        if (bus_we)
                            for (int i = 0; i < 4; i++)
                                if (bus_be[i]) mem[bus_addr][8*i +: 8] = bus_wdata[8*i +: 8];
                    end
                    req_n++;
                end else if (cyc > 0) begin
                    if (wait_n == rdly) begin
                        bus_rvalid = 1'b1;
                        bus_rdata = mem[bus_addr];
                    end
                    wait_n++;
                end
                @(posedge clk);
                #1;
            end
        end
        check({tag, " completed"}, 32'(done), 32'd1);
        mem_read = 1'b0;
        mem_write = 1'b0;
        addr = '0;
        wr_data = '0;
        func3 = 3'b000;
        bus_gnt = 1'b0;
        bus_rvalid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    int          sc, gr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [6:0]  ba;
    logic        we;

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        reset = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        addr = '0;
        wr_data = '0;
        func3 = 3'b000;
        bus_gnt = 1'b0;
        bus_rvalid = 1'b0;
        bus_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst stall", 32'(stall), 32'd0);
        check("rst bus_req", 32'(bus_req), 32'd0);
        check("rst bus_be", 32'(bus_be), 32'd0);
        check("rst bus_addr", 32'(bus_addr), 32'd0);
        check("rst rd_data", rd_data, 32'd0);
        check("rst state", 32'(dut.state_q), 32'(IDLE));

        // SW, grant in the second request cycle
        do_op("sw", 1'b0, 1'b1, 9'h010, 32'hDEADBEEF, F3_W, 1, 0, sc, be, wd, ba, we, gr);
        check("sw stall cycles", sc, 3);
        check("sw bus_addr", 32'(ba), 32'h04);
        check("sw bus_be", 32'(be), 32'hF);
        check("sw bus_wdata", wd, 32'hDEADBEEF);
        check("sw bus_we", 32'(we), 32'd1);
        check("sw grants", gr, 1);
        check("sw mem", mem[4], 32'hDEADBEEF);
        check("idle bus_be", 32'(bus_be), 32'd0);
        check("idle bus_addr", 32'(bus_addr), 32'd0);

        mem[4] = 32'h80AABBCC;
        do_op("lb", 1'b1, 1'b0, 9'h013, 32'h0, F3_B, 0, 0, sc, be, wd, ba, we, gr);
        check("lb stall cycles", sc, 3);
        check("lb bus_be", 32'(be), 32'h8);
        check("lb bus_we", 32'(we), 32'd0);
        check("lb rd_data", rd_data, 32'hFFFFFF80);
        do_op("lbu", 1'b1, 1'b0, 9'h013, 32'h0, F3_BU, 2, 1, sc, be, wd, ba, we, gr);
        check("lbu rd_data", rd_data, 32'h00000080);

        mem[4] = 32'h80011234;
        do_op("lh", 1'b1, 1'b0, 9'h012, 32'h0, F3_H, 0, 2, sc, be, wd, ba, we, gr);
        check("lh bus_be", 32'(be), 32'hC);
        check("lh rd_data", rd_data, 32'hFFFF8001);
        do_op("lhu", 1'b1, 1'b0, 9'h012, 32'h0, F3_HU, 1, 0, sc, be, wd, ba, we, gr);
        check("lhu rd_data", rd_data, 32'h00008001);
        do_op("sh", 1'b0, 1'b1, 9'h012, 32'h0000ABCD, F3_H, 0, 0, sc, be, wd, ba, we, gr);
        check("sh bus_be", 32'(be), 32'hC);
        check("sh bus_wdata", wd, 32'hABCDABCD);
        check("sh stall cycles", sc, 2);
        check("sh mem", mem[4], 32'hABCD1234);
        check("sh rd_data held", rd_data, 32'h00008001);

        // Misaligned LW
        mem_read = 1'b1;
        addr = 9'h011;
        func3 = F3_W;
        #1;
        check("mis err", 32'(access_err), 32'd1);
        check("mis stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        check("mis bus_req", 32'(bus_req), 32'd0);
        check("mis rd_data", rd_data, 32'h00008001);
        mem_read = 1'b0;

        // Illegal store size
        mem_write = 1'b1;
        addr = 9'h010;
        func3 = 3'b011;
        #1;
        check("ill err", 32'(access_err), 32'd1);
        check("ill stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        check("ill bus_req", 32'(bus_req), 32'd0);
        mem_write = 1'b0;
        func3 = 3'b000;
        #1;
        check("no err idle", 32'(access_err), 32'd0);
        @(posedge clk);
        #1;

        // SB then LW back to back with random handshake delays
        mem[1] = 32'h0;
        do_op("sb", 1'b0, 1'b1, 9'h005, 32'h1234565A, F3_B, int'($urandom_range(0, 3)), 0,
              sc, be, wd, ba, we, gr);
        check("sb bus_be", 32'(be), 32'h2);
        check("sb bus_wdata", wd, 32'h5A5A5A5A);
        check("sb grants", gr, 1);
        do_op("lw", 1'b1, 1'b0, 9'h004, 32'h0, F3_W, int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), sc, be, wd, ba, we, gr);
        check("lw grants", gr, 1);
        check("lw bus_addr", 32'(ba), 32'h01);
        check("lw rd_data", rd_data, 32'h00005A00);

        // Reset while waiting for read data, then a stray rvalid
        mem_read = 1'b1;
        addr = 9'h004;
        func3 = F3_W;
        @(posedge clk);
        #1;
        bus_gnt = 1'b1;
        @(posedge clk);
        #1;
        bus_gnt = 1'b0;
        #1;
        check("wait state", 32'(dut.state_q), 32'(WAIT_RD));
        check("wait stall", 32'(stall), 32'd1);
        reset = 1'b1;
        mem_read = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata = 32'h12345678;
        #1;
        check("mrst state", 32'(dut.state_q), 32'(IDLE));
        check("mrst stall", 32'(stall), 32'd0);
        check("mrst bus_req", 32'(bus_req), 32'd0);
        check("mrst rd_data", rd_data, 32'd0);
        @(posedge clk);
        #1;
        bus_rvalid = 1'b0;
        check("stray rvalid state", 32'(dut.state_q), 32'(IDLE));
        check("stray rvalid rd_data", rd_data, 32'd0);
        check("stray rvalid stall", 32'(stall), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage access unit. It sits between the EX/MEM pipeline register and a word-organised data memory bus that has variable latency.
- Converts func3-encoded loads and stores into byte-enabled word transactions using a req/gnt/rvalid handshake.
- Sign- or zero-extends load data.
- Raises stall to freeze the pipeline until each access completes.

Parameters:
- DATA_W, 32, data width; must be 32.
- DM_ADDRESS, 9, byte address width; word address width is DM_ADDRESS-2.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- mem_read  input  1  load request (EX/MEM MemRead)
- mem_write  input  1  store request (EX/MEM MemWrite)
- addr  input  DM_ADDRESS  byte address (ALU result)
- wr_data  input  DATA_W  store data (forwarded RD_Two)
- func3  input  3  access size/sign
- rd_data  output  DATA_W  formatted load result, held until the next load completes
- stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM
- access_err  output  1  misaligned or illegal access, combinational
- bus_req  output  1  transaction request
- bus_we  output  1  1 = write
- bus_addr  output  DM_ADDRESS-2  word address
- bus_be  output  4  byte enables
- bus_wdata  output  DATA_W  lane-replicated store data
- bus_gnt  input  1  request accepted
- bus_rvalid  input  1  read data valid
- bus_rdata  input  DATA_W  read word

Behaviour:
- Reset values:
  - state IDLE.
  - bus_req, bus_we, bus_be, bus_addr, bus_wdata = 0.
  - rd_data = 0.
  - stall = 0.
- op_valid = mem_read | mem_write. If both are set, the access is a read and the write is ignored.
- func3 decode:
  - 000 B, 001 H, 010 W, 100 BU, 101 HU.
  - Stores accept only 000/001/010.
  - Any other code is illegal.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠00.
- access_err = op_valid & (illegal | misaligned), only in IDLE.
  - On an error no bus transaction occurs and stall stays 0.
  - rd_data is unchanged; the team handles the trap elsewhere.
- State machine (states: IDLE, REQ, WAIT_RD, DONE):
  - IDLE: on a legal op, go to REQ. In the same cycle stall=1 (combinational).
    - Register bus_addr=addr[DM_ADDRESS-1:2] and bus_we=mem_write&~mem_read.
    - Register bus_be: B → 1<<addr[1:0]; H → addr[1]?1100:0011; W → 1111; for loads use the same lane rule.
    - Register bus_wdata: byte replicated ×4, half ×2, word as-is.
  - REQ: bus_req=1, stall=1, all bus outputs held stable.
    - On bus_gnt: a write goes to DONE; a read goes to WAIT_RD.
    - bus_gnt in the first REQ cycle is legal, giving minimum latency.
  - WAIT_RD: bus_req=0, stall=1.
    - On bus_rvalid, capture into rd_data the lane selected by addr[1:0] (B/H), sign-extended for B/H and zero-extended for BU/HU; then go to DONE.
    - bus_rvalid in the same cycle as bus_gnt (while in REQ) is not allowed; the memory must return data at least one cycle after gnt.
  - DONE: stall=0 and bus_req=0. Inputs are ignored, so the same op is not re-issued. Always return to IDLE.
    - The pipeline advances on this edge; MEM/WB samples rd_data in the following cycle (rd_data valid from DONE onward).
- Latency: a store takes 3 cycles minimum (IDLE→REQ→DONE); a load takes 4 cycles minimum.
- Back-to-back ops: the next op is seen in IDLE on the cycle after DONE.
- Reset mid-transaction: go to IDLE next cycle and drop the bus request. A stray bus_rvalid/bus_gnt seen in IDLE or DONE is ignored.
- bus_be lanes and bus_addr are zero while in IDLE.

Decomposition:
- Extend Pipe_Buf_Reg_PKG:
  - lsu_state_e enum {IDLE, REQ, WAIT_RD, DONE}.
  - func3 localparams F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
- Sub-module load_format, combinational: (func3, addr[1:0], bus_rdata) → extended load word; reused by the bench scoreboard.
- Store-lane generation stays inline.

Test Plan:
- SW addr=0x010, wr_data=0xDEADBEEF, gnt 2 cycles after req → bus_addr=0x04, be=1111, wdata=0xDEADBEEF, we=1. stall high for exactly 3 cycles, then low for one cycle (DONE).
- LB addr=0x013, rdata=0x80AABBCC → be=1000, rd_data=0xFFFFFF80. LBU at the same address → 0x00000080.
- LH addr=0x012, rdata=0x8001_1234 → rd_data=0xFFFF8001. LHU → 0x00008001. SH addr=0x012, wr_data=0x0000ABCD → be=1100, wdata=0xABCDABCD.
- Misaligned LW addr=0x011, and func3=011 with mem_write → access_err=1 that cycle, no bus_req, stall=0, rd_data unchanged.
- SB addr=0x005 followed immediately by LW addr=0x004, gnt/rvalid delayed 0–3 cycles at random → two distinct transactions, no duplicate issue, LW returns the stored byte in lane 1.
- Assert reset while in WAIT_RD, then pulse bus_rvalid in the following cycle → state IDLE, rd_data=0, stall=0, bus_req=0.
